// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Opcode map, forward-select encodings, FSM states and the source-operand decoder.
package hazard_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FWD_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0100;
  localparam logic [OP_W-1:0] OP_LW   = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW   = 4'b1001;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1010;
  localparam logic [OP_W-1:0] OP_NOP  = 4'b1111;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_t;

  typedef struct packed {
    logic uses_a;   // instruction reads rs
    logic uses_b;   // instruction reads a second register
    logic b_is_rd;  // second source sits in the rd field (stores, branches)
  } src_use_t;

  // Which register fields an opcode actually reads; undefined opcodes read nothing.
  function automatic src_use_t decode_srcs(input logic [OP_W-1:0] op);
    src_use_t u;
    u = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        u.uses_a = 1'b1;
        u.uses_b = 1'b1;
      end
      OP_ADDI, OP_LW: u.uses_a = 1'b1;
      OP_SW, OP_BEQ: begin
        u.uses_a  = 1'b1;
        u.uses_b  = 1'b1;
        u.b_is_rd = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 16-bit 5-stage core: load-use stalls, branch flushes,
// memory-busy freeze, registered EX forwarding selects and saturating statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NREG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic [NREG_W-1:0]  ex_rd,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic [NREG_W-1:0]  mem_rd,
  input  logic               mem_regwrite,
  input  logic               branch_taken,
  input  logic               mem_busy,
  input  logic               cnt_clr,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               idex_we,
  output logic               idex_bubble,
  output logic [FWD_W-1:0]   fwd_a_sel,
  output logic [FWD_W-1:0]   fwd_b_sel,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   freeze_cnt
);

  state_t            state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  src_use_t          use_c;
  logic [NREG_W-1:0] rd_c, rs_c, rt_c;
  logic [NREG_W-1:0] src_a_c, src_b_c;
  logic              need_a_c, need_b_c;
  logic              load_use_c;
  logic              stall_c, flush_c;
  logic [FWD_W-1:0]  fwd_a_c, fwd_b_c;

  // Source operand decode; register 0 and invalid slots never take part.
  assign use_c    = decode_srcs(id_instr[15:12]);
  assign rd_c     = NREG_W'(id_instr[11:8]);
  assign rs_c     = NREG_W'(id_instr[7:4]);
  assign rt_c     = NREG_W'(id_instr[3:0]);
  assign src_a_c  = rs_c;
  assign src_b_c  = use_c.b_is_rd ? rd_c : rt_c;
  assign need_a_c = id_valid && use_c.uses_a && (src_a_c != '0);
  assign need_b_c = id_valid && use_c.uses_b && (src_b_c != '0);

  assign load_use_c = ex_memread && ex_regwrite && (ex_rd != '0) &&
                      ((need_a_c && (src_a_c == ex_rd)) ||
                       (need_b_c && (src_b_c == ex_rd)));

  // Nearest producer wins: EX/MEM result is younger than MEM/WB.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic need,
                                               input logic [NREG_W-1:0] src);
    if (need && ex_regwrite && (ex_rd == src)) begin
      return FWD_EXMEM;
    end else if (need && mem_regwrite && (mem_rd == src)) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

  assign fwd_a_c = fwd_sel(need_a_c, src_a_c);
  assign fwd_b_c = fwd_sel(need_b_c, src_b_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next state and pipeline enables; freeze beats flush beats load-use stall.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    stall_c      = 1'b0;
    flush_c      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d      = ST_FREEZE;
          flush_pend_d = flush_pend_q || branch_taken;
        end
      end
      ST_FREEZE: begin
        if (mem_busy) begin
          flush_pend_d = flush_pend_q || branch_taken;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (mem_busy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
    end else if (branch_taken || flush_pend_q) begin
      flush_c      = 1'b1;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      flush_pend_d = 1'b0;
    end else if (load_use_c) begin
      stall_c     = 1'b1;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Selects follow the instruction into ID/EX; a bubble carries no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (idex_we) begin
      if (idex_bubble) begin
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else begin
        fwd_a_sel <= fwd_a_c;
        fwd_b_sel <= fwd_b_c;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_c),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (flush_c),
    .cnt   (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (mem_busy),
    .cnt   (freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int          CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id_instr;
  logic        id_valid;
  logic [3:0]  ex_rd, mem_rd;
  logic        ex_regwrite, ex_memread, mem_regwrite;
  logic        branch_taken, mem_busy, cnt_clr;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: pending flush, registered selects, counters.
  bit         m_pend;
  logic [1:0] m_fa, m_fb;
  int         m_stall, m_flush, m_freeze;

  hazard_ctrl #(.CNT_W(CNT_W), .NREG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .cnt_clr      (cnt_clr),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_we      (idex_we),
    .idex_bubble  (idex_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .freeze_cnt   (freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
  endfunction

  // Registers read by an instruction, by opcode class.
  task automatic model_srcs(output bit ua, output bit ub,
                            output logic [3:0] ra, output logic [3:0] rb);
    int op;
    op = int'(id_instr[15:12]);
    ra = id_instr[7:4];
    rb = id_instr[3:0];
    ua = 0;
    ub = 0;
    if (op <= 3) begin
      ua = 1; ub = 1;
    end else if (op == 4 || op == 8) begin
      ua = 1;
    end else if (op == 9 || op == 10) begin
      ua = 1; ub = 1; rb = id_instr[11:8];
    end
    if (!id_valid) begin
      ua = 0; ub = 0;
    end
  endtask

  function automatic logic [1:0] model_fwd(input bit u, input logic [3:0] r);
    if (!u || r == 4'd0) return 2'b00;
    if (ex_regwrite && ex_rd == r) return 2'b01;
    if (mem_regwrite && mem_rd == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int next_cnt(input int c, input bit inc);
    if (cnt_clr) return 0;
    if (inc && c < CNT_MAX) return c + 1;
    return c;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_fa = 2'b00; m_fb = 2'b00;
    m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(m_fa));
    chk({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(m_fb));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    chk({tag, ".freeze_cnt"}, 32'(freeze_cnt), 32'(m_freeze));
  endtask

  // One cycle: inputs already driven at the falling edge.
  task automatic step(input string tag);
    bit ua, ub, lu, fz, fl, st;
    logic [3:0] ra, rb;
    #1;
    model_srcs(ua, ub, ra, rb);
    lu = ex_memread && ex_regwrite && ex_rd != 0 &&
         ((ua && ra == ex_rd) || (ub && rb == ex_rd));
    fz = mem_busy;
    fl = !fz && (branch_taken || m_pend);
    st = !fz && !fl && lu;
    chk({tag, ".pc_we"}, 32'(pc_we), 32'(!fz && !st));
    chk({tag, ".ifid_we"}, 32'(ifid_we), 32'(!fz && !st));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    chk({tag, ".idex_we"}, 32'(idex_we), 32'(!fz));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(fl || st));
    if (!fz) begin
      m_fa = (fl || st) ? 2'b00 : model_fwd(ua, ra);
      m_fb = (fl || st) ? 2'b00 : model_fwd(ub, rb);
    end
    m_pend   = fz ? (m_pend || branch_taken) : 0;
    m_stall  = next_cnt(m_stall, st);
    m_flush  = next_cnt(m_flush, fl);
    m_freeze = next_cnt(m_freeze, fz);
    @(posedge clk);
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic quiet();
    id_instr = mk(15, 0, 0, 0); id_valid = 1'b1;
    ex_rd = 4'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 4'd0; mem_regwrite = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset.pc_we", 32'(pc_we), 32'd1);
    chk("reset.ifid_we", 32'(ifid_we), 32'd1);
    chk("reset.idex_we", 32'(idex_we), 32'd1);
    chk("reset.ifid_flush", 32'(ifid_flush), 32'd0);
    chk("reset.idex_bubble", 32'(idex_bubble), 32'd0);
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LW r3 in EX, ADD r4,r3,r5 in ID: one bubble, then MEM/WB forward.
    ex_rd = 4'd3; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_instr = mk(0, 4, 3, 5);
    step("lu_stall");
    chk("lu_stall.count", 32'(stall_cnt), 32'd1);
    ex_rd = 4'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 4'd3; mem_regwrite = 1'b1;
    step("lu_resolve");
    chk("lu_resolve.fwd_a", 32'(fwd_a_sel), 32'd2);

    // EX and MEM both write r1: EX wins on both operands.
    quiet();
    ex_rd = 4'd1; ex_regwrite = 1'b1;
    mem_rd = 4'd1; mem_regwrite = 1'b1;
    id_instr = mk(1, 6, 1, 1);
    step("ex_prio");
    chk("ex_prio.fwd_ab", 32'({fwd_a_sel, fwd_b_sel}), 32'h5);

    // Branch overrides a load-use hazard.
    quiet();
    ex_rd = 4'd3; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_instr = mk(0, 4, 3, 5); branch_taken = 1'b1;
    step("br_over_lu");
    chk("br_over_lu.counts", 32'({stall_cnt, flush_cnt}), 32'h0001_0001);

    // Freeze for three cycles with a branch landing in the middle.
    quiet(); cnt_clr = 1'b1;
    step("clr1");
    cnt_clr = 1'b0; mem_busy = 1'b1;
    step("frz1");
    branch_taken = 1'b1;
    step("frz2");
    branch_taken = 1'b0;
    step("frz3");
    mem_busy = 1'b0;
    step("frz_exit");
    chk("frz_exit.counts", 32'({freeze_cnt, flush_cnt}), 32'h0003_0001);
    step("frz_after");

    // Register 0 and invalid slots never stall or forward.
    ex_rd = 4'd0; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_instr = mk(0, 4, 0, 0);
    step("r0_src");
    ex_rd = 4'd3; id_valid = 1'b0; id_instr = mk(0, 4, 3, 3);
    step("invalid");
    chk("invalid.fwd_ab", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);

    // Reset mid-freeze with a pending flush.
    quiet(); mem_busy = 1'b1;
    step("rst_frz1");
    branch_taken = 1'b1;
    step("rst_frz2");
    quiet();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid.ifid_flush", 32'(ifid_flush), 32'd0);
    chk("rst_mid.pc_we", 32'(pc_we), 32'd1);
    check_regs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release");
    chk("rst_release.no_flush", 32'(flush_cnt), 32'd0);

    // Randomized traffic over a small register window to force collisions.
    for (int i = 0; i < 400; i++) begin
      id_instr     = mk($urandom_range(0, 15), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
      id_valid     = ($urandom_range(0, 7) != 0);
      ex_rd        = 4'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 1));
      mem_rd       = 4'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy     = ($urandom_range(0, 3) == 0);
      cnt_clr      = ($urandom_range(0, 31) == 0);
      step($sformatf("rnd%0d", i));
    end

    // Drive stall_cnt into saturation, then clear it.
    quiet();
    step("sat_settle");
    ex_rd = 4'd3; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_instr = mk(0, 4, 3, 5); cnt_clr = 1'b1;
    step("sat_clr");
    cnt_clr = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    m_stall = CNT_MAX; m_fa = 2'b00; m_fb = 2'b00;
    check_regs("sat_top");
    @(negedge clk);
    step("sat_hold");
    chk("sat_hold.value", 32'(stall_cnt), 32'hFFFF);
    cnt_clr = 1'b1;
    step("sat_cleared");
    chk("sat_cleared.value", 32'(stall_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 16-bit 5-stage MIPS-style core.
- Instruction format: op[15:12], rd[11:8], rs[7:4], rt/imm[3:0]. The 4-bit imm is sign-extended in ID.
- Detects load-use hazards, inserts bubbles and flushes on taken branches. Freezes the pipe while data memory is busy.
- Registers EX-stage forwarding selects and keeps saturating hazard statistics counters.

Parameters:
CNT_W, 16, width of each statistics counter
NREG_W, 4, register-index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_instr  in  16  instruction currently in IF/ID
id_valid  in  1  IF/ID holds a real instruction
ex_rd  in  4  destination register of the EX-stage instruction
ex_regwrite  in  1  EX instruction writes the register file
ex_memread  in  1  EX instruction is LW
mem_rd  in  4  destination register of the MEM-stage instruction
mem_regwrite  in  1  MEM instruction writes the register file
branch_taken  in  1  branch resolved taken in EX (1-cycle pulse)
mem_busy  in  1  data memory not ready; pipeline must hold
cnt_clr  in  1  synchronous clear of all counters
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  zero IF/ID on next edge
idex_we  out  1  ID/EX write enable
idex_bubble  out  1  load NOP into ID/EX on next edge
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  EX operand B source, same encoding
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  branch flushes
freeze_cnt  out  CNT_W  mem_busy cycles

Behaviour:
- Reset (async, rst_n=0):
  - State is RUN.
  - flush_pend=0; fwd_a_sel=fwd_b_sel=00; all counters 0.
  - Enables pc_we=ifid_we=idex_we=1; ifid_flush=idex_bubble=0.
  - Reset mid-freeze discards the pending flush.
- Source decode (opcode constants are in the package):
  - ADD/SUB/AND/OR (0000-0011): srcA=rs, srcB=rt.
  - ADDI (0100) and LW (1000): srcA=rs only.
  - SW (1001) and BEQ (1010): srcA=rs, srcB=rd.
  - NOP (1111) and undefined opcodes: no sources.
  - Register 0 never causes a hazard or a forward.
  - id_valid=0 means no sources.
- Load-use: asserted when ex_memread & ex_regwrite & ex_rd!=0 & ex_rd equals any used source.
  - Outputs that cycle: pc_we=0, ifid_we=0, idex_bubble=1.
  - Exactly one bubble per LW; the following cycle is resolved by forwarding.
- Output priority, evaluated combinationally from state and inputs (highest first):
  1. FREEZE (mem_busy=1): pc_we=ifid_we=idex_we=0; flush and bubble 0.
  2. Flush (branch_taken, or flush_pend in RUN): pc_we=1, ifid_flush=1, idex_bubble=1. The load-use stall is ignored.
  3. Load-use stall.
  4. Normal: all enables 1.
- FSM:
  - RUN -> FREEZE when mem_busy=1.
  - FREEZE -> RUN when mem_busy=0.
  - A branch_taken during FREEZE sets flush_pend. The flush is applied in the first RUN cycle, then flush_pend clears.
  - A branch_taken and mem_busy in the same cycle also sets flush_pend.
- Forwarding: computed in ID, registered on edges where idex_we=1.
  - Per operand: sel=01 if ex_regwrite & ex_rd!=0 & ex_rd==src. Else sel=10 if mem_regwrite & mem_rd!=0 & mem_rd==src. Else 00.
  - EX match has priority over MEM match.
  - Register 00 into both selects when a bubble or flush is loaded.
  - Hold the selects while idex_we=0.
  - The regfile is write-first, so WB-stage matches need no forward.
- Counters:
  - Each increments by 1 per qualifying cycle: stall_cnt on a load-use stall, flush_cnt on each flush, freeze_cnt on each FREEZE cycle.
  - Counters saturate at all-ones.
  - cnt_clr has priority over increment.

Decomposition:
- Package hazard_pkg: opcode localparams (OP_ADD..OP_NOP), FWD_RF/FWD_EXMEM/FWD_MEMWB encodings, state encoding (ST_RUN, ST_FREEZE), and a function that decodes uses_a/uses_b from an opcode.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
- LW r3,1(r2) in EX, ADD r4,r3,r5 in ID -> one cycle with pc_we=0, ifid_we=0, idex_bubble=1. Next cycle all enables 1 and fwd_a_sel registers 10. stall_cnt=1.
- ADD r1 in EX, SUB r6,r1,r1 in ID, MEM writing r1 -> fwd_a_sel=fwd_b_sel=01 (EX priority). No stall.
- branch_taken=1 while LW hazard present -> ifid_flush=1, idex_bubble=1, pc_we=1. stall_cnt unchanged, flush_cnt=1.
- mem_busy high 3 cycles with branch_taken pulsed in the 2nd -> enables 0 for 3 cycles. Flush occurs on the 4th cycle. freeze_cnt=3, flush_cnt=1.
- LW r0 / ADD reading r0, and id_valid=0 with matching fields -> no stall, selects 00.
- rst_n low mid-freeze with flush_pend set -> immediate reset values. No flush after release. Counters 0.
- Preload stall_cnt near 0xFFFF via repeated hazards -> holds at 0xFFFF. cnt_clr -> 0.
